servo_sweep_scheduler: RTL and testbench



---
 rtl/echo_pkg.sv | 17 +
 rtl/servo_sweep_scheduler_if.sv | 32 +++
 rtl/sweep_angle_gen.sv | 63 ++++++
 rtl/servo_sweep_scheduler.sv | 121 ++++++++++++
 tb/tb_servo_sweep_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types and constants for the servo sweep / ranging path
package echo_pkg;

  localparam int DIST_W  = 16;
  localparam int ANGLE_W = 8;

  localparam logic [DIST_W-1:0] DIST_TIMEOUT_CODE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT,
    STEP
  } state_t;

endpackage

// File: rtl/servo_sweep_scheduler_if.sv
// rtl/servo_sweep_scheduler_if.sv - ranging handshake and sample stream between scheduler and its neighbours
interface servo_sweep_scheduler_if;

  logic                          meas_req;
  logic                          meas_done;
  logic [echo_pkg::DIST_W-1:0]   meas_dist;
  logic                          sample_valid;
  logic [echo_pkg::ANGLE_W-1:0]  sample_angle;
  logic [echo_pkg::DIST_W-1:0]   sample_dist;
  logic                          sample_timeout;

  modport master (
    output meas_req,
    output sample_valid,
    output sample_angle,
    output sample_dist,
    output sample_timeout,
    input  meas_done,
    input  meas_dist
  );

  modport slave (
    input  meas_req,
    input  sample_valid,
    input  sample_angle,
    input  sample_dist,
    input  sample_timeout,
    output meas_done,
    output meas_dist
  );

endinterface

// File: rtl/sweep_angle_gen.sv
// rtl/sweep_angle_gen.sv - angle/direction registers with clamp-and-reverse stepping
module sweep_angle_gen
  import echo_pkg::*;
#(
  parameter int unsigned ANGLE_MIN  = 0,
  parameter int unsigned ANGLE_MAX  = 255,
  parameter int unsigned ANGLE_STEP = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output logic [ANGLE_W-1:0] angle,
  output logic               sweep_dir
);

  // One extra bit so up/down moves can be clamped before they wrap.
  localparam int EW = ANGLE_W + 1;
  localparam logic [EW-1:0] MIN_E  = EW'(ANGLE_MIN);
  localparam logic [EW-1:0] MAX_E  = EW'(ANGLE_MAX);
  localparam logic [EW-1:0] STEP_E = EW'(ANGLE_STEP);

  logic [EW-1:0]      angle_ext;
  logic [EW-1:0]      up_sum;
  logic [EW-1:0]      up_clamp;
  logic [EW-1:0]      down_clamp;
  logic [ANGLE_W-1:0] next_angle;
  logic               next_dir;

  always_comb begin
    angle_ext  = {1'b0, angle};
    up_sum     = angle_ext + STEP_E;
    up_clamp   = (up_sum > MAX_E) ? MAX_E : up_sum;
    down_clamp = (angle_ext < MIN_E + STEP_E) ? MIN_E : (angle_ext - STEP_E);
    next_angle = angle;
    next_dir   = sweep_dir;
    if (sweep_dir) begin
      if (angle_ext == MAX_E) begin
        next_dir   = 1'b0;
        next_angle = ANGLE_W'(down_clamp);
      end else begin
        next_angle = ANGLE_W'(up_clamp);
      end
    end else begin
      if (angle_ext == MIN_E) begin
        next_dir   = 1'b1;
        next_angle = ANGLE_W'(up_clamp);
      end else begin
        next_angle = ANGLE_W'(down_clamp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle     <= ANGLE_W'(ANGLE_MIN);
      sweep_dir <= 1'b1;
    end else if (step) begin
      angle     <= next_angle;
      sweep_dir <= next_dir;
    end
  end

endmodule

// File: rtl/servo_sweep_scheduler.sv
// rtl/servo_sweep_scheduler.sv - settle / measure / report sequencer for the servo ranging sweep
module servo_sweep_scheduler
  import echo_pkg::*;
#(
  parameter int unsigned ANGLE_MIN     = 0,
  parameter int unsigned ANGLE_MAX     = 255,
  parameter int unsigned ANGLE_STEP    = 8,
  parameter int unsigned SETTLE_FRAMES = 3,
  parameter int unsigned MEAS_TIMEOUT  = 1_500_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      cycle_done,
  output logic [ANGLE_W-1:0]        angle,
  output logic                      sweep_dir,
  output logic                      busy,
  servo_sweep_scheduler_if.master   rng
);

  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int TW = $clog2(MEAS_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_FRAMES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEAS_TIMEOUT - 1);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          step;

  sweep_angle_gen #(
    .ANGLE_MIN (ANGLE_MIN),
    .ANGLE_MAX (ANGLE_MAX),
    .ANGLE_STEP(ANGLE_STEP)
  ) u_angle_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .angle    (angle),
    .sweep_dir(sweep_dir)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      settle_cnt         <= '0;
      timeout_cnt        <= '0;
      step               <= 1'b0;
      busy               <= 1'b0;
      rng.meas_req       <= 1'b0;
      rng.sample_valid   <= 1'b0;
      rng.sample_angle   <= '0;
      rng.sample_dist    <= '0;
      rng.sample_timeout <= 1'b0;
    end else begin
      rng.sample_valid <= 1'b0;
      step             <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end

        SETTLE: begin
          if (!enable) begin
            state      <= IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
          end else if (cycle_done) begin
            if (settle_cnt == SETTLE_LAST) begin
              state        <= MEASURE;
              settle_cnt   <= '0;
              timeout_cnt  <= '0;
              rng.meas_req <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        MEASURE: begin
          timeout_cnt <= timeout_cnt + 1'b1;
          // A result landing on the expiry clock still counts as a real measurement.
          if (rng.meas_done || timeout_cnt == TIMEOUT_LAST) begin
            state              <= REPORT;
            rng.meas_req       <= 1'b0;
            rng.sample_valid   <= 1'b1;
            rng.sample_angle   <= angle;
            rng.sample_dist    <= rng.meas_done ? rng.meas_dist : DIST_TIMEOUT_CODE;
            rng.sample_timeout <= !rng.meas_done;
            step               <= 1'b1;
          end
        end

        REPORT: begin
          state <= STEP;
        end

        STEP: begin
          // Angle already advanced on the REPORT edge; only the exit decision remains.
          if (enable) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_sweep_scheduler.sv
// tb/tb_servo_sweep_scheduler.sv - directed self-checking bench for servo_sweep_scheduler
module tb_servo_sweep_scheduler;
  import echo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cycle_done = 1'b0;
  logic [7:0] angle;
  logic       sweep_dir;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  servo_sweep_scheduler_if bus ();

  servo_sweep_scheduler #(
    .ANGLE_MIN    (0),
    .ANGLE_MAX    (200),
    .ANGLE_STEP   (64),
    .SETTLE_FRAMES(2),
    .MEAS_TIMEOUT (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cycle_done(cycle_done),
    .angle     (angle),
    .sweep_dir (sweep_dir),
    .busy      (busy),
    .rng       (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    cycle_done    = 1'b0;
    bus.meas_done = 1'b0;
    bus.meas_dist = '0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic pulse_cd();
    cycle_done = 1'b1;
    next_cyc();
    cycle_done = 1'b0;
  endtask

  task automatic settle2();
    pulse_cd();
    next_cyc();
    pulse_cd();
  endtask

  task automatic pulse_md(input logic [15:0] d);
    bus.meas_dist = d;
    bus.meas_done = 1'b1;
    next_cyc();
    bus.meas_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (angle !== 8'd0) begin mismatched++; $display("FAIL reset_angle got %0d exp 0", angle); end
    compared++; if (sweep_dir !== 1'b1) begin mismatched++; $display("FAIL reset_dir got %b exp 1", sweep_dir); end
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL reset_meas_req got %b exp 0", bus.meas_req); end
    compared++; if (bus.sample_valid !== 1'b0) begin mismatched++; $display("FAIL reset_sample_valid got %b exp 0", bus.sample_valid); end
    compared++; if (bus.sample_dist !== 16'h0) begin mismatched++; $display("FAIL reset_sample_dist got %h exp 0", bus.sample_dist); end
    compared++; if (bus.sample_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout got %b exp 0", bus.sample_timeout); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_first_sample();
    enable = 1'b1;
    next_cyc();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL t1_busy got %b exp 1", busy); end
    pulse_cd();
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL t1_req_early got %b exp 0", bus.meas_req); end
    next_cyc();
    pulse_cd();
    compared++; if (bus.meas_req !== 1'b1) begin mismatched++; $display("FAIL t1_req_rise got %b exp 1", bus.meas_req); end
    pulse_md(16'h1234);
    compared++; if (bus.sample_valid !== 1'b1) begin mismatched++; $display("FAIL t1_valid got %b exp 1", bus.sample_valid); end
    compared++; if (bus.sample_angle !== 8'd0) begin mismatched++; $display("FAIL t1_sample_angle got %0d exp 0", bus.sample_angle); end
    compared++; if (bus.sample_dist !== 16'h1234) begin mismatched++; $display("FAIL t1_dist got %h exp 1234", bus.sample_dist); end
    compared++; if (bus.sample_timeout !== 1'b0) begin mismatched++; $display("FAIL t1_timeout got %b exp 0", bus.sample_timeout); end
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL t1_req_fall got %b exp 0", bus.meas_req); end
    next_cyc();
    compared++; if (bus.sample_valid !== 1'b0) begin mismatched++; $display("FAIL t1_valid_pulse got %b exp 0", bus.sample_valid); end
    compared++; if (angle !== 8'd64) begin mismatched++; $display("FAIL t1_next_angle got %0d exp 64", angle); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_a [10] = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd200, 8'd136, 8'd72, 8'd8, 8'd0, 8'd64};
    logic [7:0] exp_n [10] = '{8'd64, 8'd128, 8'd192, 8'd200, 8'd136, 8'd72, 8'd8, 8'd0, 8'd64, 8'd128};
    logic       exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] d;
    do_reset();
    enable = 1'b1;
    next_cyc();
    for (int i = 0; i < 10; i++) begin
      d = 16'h0100 + 16'(i);
      settle2();
      pulse_md(d);
      compared++; if (bus.sample_valid !== 1'b1) begin mismatched++; $display("FAIL sweep_valid[%0d] got %b exp 1", i, bus.sample_valid); end
      compared++; if (bus.sample_angle !== exp_a[i]) begin mismatched++; $display("FAIL sweep_angle[%0d] got %0d exp %0d", i, bus.sample_angle, exp_a[i]); end
      compared++; if (bus.sample_dist !== d) begin mismatched++; $display("FAIL sweep_dist[%0d] got %h exp %h", i, bus.sample_dist, d); end
      next_cyc();
      compared++; if (angle !== exp_n[i]) begin mismatched++; $display("FAIL sweep_next[%0d] got %0d exp %0d", i, angle, exp_n[i]); end
      compared++; if (sweep_dir !== exp_d[i]) begin mismatched++; $display("FAIL sweep_dir[%0d] got %b exp %b", i, sweep_dir, exp_d[i]); end
      next_cyc();
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    enable = 1'b1;
    next_cyc();
    settle2();
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (!bus.meas_req) break;
      cnt++;
      next_cyc();
    end
    compared++; if (cnt !== 100) begin mismatched++; $display("FAIL to_req_len got %0d exp 100", cnt); end
    compared++; if (bus.sample_valid !== 1'b1) begin mismatched++; $display("FAIL to_valid got %b exp 1", bus.sample_valid); end
    compared++; if (bus.sample_dist !== 16'hFFFF) begin mismatched++; $display("FAIL to_dist got %h exp ffff", bus.sample_dist); end
    compared++; if (bus.sample_timeout !== 1'b1) begin mismatched++; $display("FAIL to_flag got %b exp 1", bus.sample_timeout); end
    next_cyc();
    compared++; if (angle !== 8'd64) begin mismatched++; $display("FAIL to_next_angle got %0d exp 64", angle); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    next_cyc();
    pulse_cd();
    enable = 1'b0;
    next_cyc();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL drop_busy got %b exp 0", busy); end
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL drop_req got %b exp 0", bus.meas_req); end
    compared++; if (angle !== 8'd0) begin mismatched++; $display("FAIL drop_angle got %0d exp 0", angle); end
    pulse_cd();
    next_cyc();
    pulse_cd();
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL drop_idle_req got %b exp 0", bus.meas_req); end
    enable = 1'b1;
    next_cyc();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL reen_busy got %b exp 1", busy); end
    pulse_cd();
    next_cyc();
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL reen_req_early got %b exp 0", bus.meas_req); end
    pulse_cd();
    compared++; if (bus.meas_req !== 1'b1) begin mismatched++; $display("FAIL reen_req got %b exp 1", bus.meas_req); end
  endtask

  task automatic test_reset_mid_measure();
    do_reset();
    enable = 1'b1;
    next_cyc();
    settle2();
    pulse_md(16'h0055);
    next_cyc();
    next_cyc();
    settle2();
    compared++; if (bus.meas_req !== 1'b1) begin mismatched++; $display("FAIL rm_req_before got %b exp 1", bus.meas_req); end
    compared++; if (angle !== 8'd64) begin mismatched++; $display("FAIL rm_angle_before got %0d exp 64", angle); end
    rst_n  = 1'b0;
    enable = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL rm_req got %b exp 0", bus.meas_req); end
    compared++; if (angle !== 8'd0) begin mismatched++; $display("FAIL rm_angle got %0d exp 0", angle); end
    compared++; if (sweep_dir !== 1'b1) begin mismatched++; $display("FAIL rm_dir got %b exp 1", sweep_dir); end
    compared++; if (bus.sample_dist !== 16'h0) begin mismatched++; $display("FAIL rm_dist got %h exp 0", bus.sample_dist); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rm_busy got %b exp 0", busy); end
    pulse_md(16'h7777);
    compared++; if (bus.sample_valid !== 1'b0) begin mismatched++; $display("FAIL rm_late_done got %b exp 0", bus.sample_valid); end
  endtask

  task automatic test_done_coincident();
    do_reset();
    enable = 1'b1;
    next_cyc();
    pulse_cd();
    next_cyc();
    pulse_md(16'h4444);
    compared++; if (bus.sample_valid !== 1'b0) begin mismatched++; $display("FAIL co_settle_done got %b exp 0", bus.sample_valid); end
    compared++; if (bus.meas_req !== 1'b0) begin mismatched++; $display("FAIL co_settle_req got %b exp 0", bus.meas_req); end
    next_cyc();
    pulse_cd();
    compared++; if (bus.meas_req !== 1'b1) begin mismatched++; $display("FAIL co_req got %b exp 1", bus.meas_req); end
    for (int k = 0; k < 99; k++) next_cyc();
    compared++; if (bus.meas_req !== 1'b1) begin mismatched++; $display("FAIL co_req_last got %b exp 1", bus.meas_req); end
    pulse_md(16'hABCD);
    compared++; if (bus.sample_valid !== 1'b1) begin mismatched++; $display("FAIL co_valid got %b exp 1", bus.sample_valid); end
    compared++; if (bus.sample_timeout !== 1'b0) begin mismatched++; $display("FAIL co_timeout got %b exp 0", bus.sample_timeout); end
    compared++; if (bus.sample_dist !== 16'hABCD) begin mismatched++; $display("FAIL co_dist got %h exp abcd", bus.sample_dist); end
  endtask

  initial begin
    bus.meas_done = 1'b0;
    bus.meas_dist = '0;
    test_reset();
    test_first_sample();
    test_sweep();
    test_timeout();
    test_enable_drop();
    test_reset_mid_measure();
    test_done_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
